countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter PRESCALE, default 50000000, CLK cycles per count tick; legal range 2 and up.
REQ-002 CLK  input  1  clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 LOAD  input  1  synchronous level; loads preset digits when high.
REQ-005 LOAD_TENS  input  4  BCD preset, tens digit.
REQ-006 LOAD_ONES  input  4  BCD preset, ones digit.
REQ-007 START_STOP  input  1  synchronous control; only its rising edge acts.
REQ-008 TENS  output  4  current tens digit, BCD.
REQ-009 ONES  output  4  current ones digit, BCD.
REQ-010 RUNNING  output  1  high only in state RUN.
REQ-011 DONE  output  1  single-cycle pulse on expiry.
REQ-012 BUZZ  output  1  high only in state EXPIRED.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, PAUSE and EXPIRED.
REQ-014 Edge detection SHALL register START_STOP each cycle: edge = START_STOP high and previous sample low; a held-high level yields exactly one edge.
REQ-015 Transitions on edge, effective at the same CLK edge:
- IDLE to RUN when count is not 00; IDLE stays IDLE when count is 00.
- RUN to PAUSE.
- PAUSE to RUN.
- EXPIRED to IDLE; count stays 00.
REQ-016 LOAD in IDLE, PAUSE or EXPIRED SHALL:
- latch the digits;
- clamp any digit above 9 to 9;
- clear the prescaler;
- go to IDLE.
REQ-017 LOAD in RUN SHALL be ignored.
REQ-018 LOAD together with an edge in a non-RUN state: LOAD wins and the edge is discarded.
REQ-019 The prescaler SHALL count 0 to PRESCALE-1 only in RUN, hold its value in PAUSE, and be cleared on IDLE to RUN.
REQ-020 A tick SHALL occur in the RUN cycle where prescaler equals PRESCALE-1; the prescaler wraps to 0.
REQ-021 On a tick the count SHALL decrement in BCD:
- ones above 0: ones minus 1;
- otherwise: ones becomes 9 and tens minus 1.
REQ-022 A tick at count 01 SHALL set the count to 00 and the state to EXPIRED on the same edge.
REQ-023 DONE SHALL be high for exactly the one cycle following entry to EXPIRED.
REQ-024 An edge and a tick in the same RUN cycle: the tick is applied first, then RUN goes to PAUSE. If that tick expires the count, EXPIRED wins and the edge is discarded.
REQ-025 The count SHALL never wrap below 00 and SHALL never hold a non-BCD digit.
REQ-026 All outputs SHALL be registered, or decoded only from registered state.

Reset
REQ-027 On RST low, asynchronously:
- state IDLE;
- TENS and ONES 0;
- prescaler 0;
- edge-detect sample 0;
- RUNNING, DONE and BUZZ 0.
REQ-028 Reset asserted mid-RUN SHALL abort the countdown with no DONE pulse; operation resumes in IDLE on the first edge after RST goes high.

Structure
REQ-029 Package countdown_pkg SHALL hold:
- the state encoding typedef;
- the PRESCALE default;
- the BCD digit maximum constant (9).
REQ-030 Rising-edge detection SHALL be one sub-module, edge_detect (CLK, RST, IN, EDGE), with the same reset style.
REQ-031 The prescaler, FSM and BCD digit registers SHALL remain in countdown_timer.

Verification (PRESCALE=4)
REQ-032 Load 03, edge, no further input:
- RUNNING high;
- count 02, 01, 00 at 4-cycle intervals;
- EXPIRED entered with 00;
- DONE high for 1 cycle, BUZZ held high.
REQ-033 Load 10, edge, run 1 tick: count 09 (borrow case). Load 9F in IDLE: count 99 (clamp).
REQ-034 Load 05, edge; after 2 cycles edge (PAUSE); wait 20 cycles; edge:
- count holds during PAUSE;
- next tick arrives 2 cycles after resume (prescaler retained).
REQ-035 START_STOP held high 10 cycles in IDLE with count 05: exactly one transition to RUN. Edge with count 00: stays IDLE.
REQ-036 Pulse RST low mid-RUN at count 07: all outputs 0 immediately; no DONE. LOAD asserted during RUN: count unaffected.
REQ-037 In EXPIRED: edge goes to IDLE with BUZZ low. LOAD 12 with a simultaneous edge: IDLE, count 12, RUNNING low.

Source files
------------

// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared definitions for the two-digit BCD countdown timer: the FSM state
// encoding, the default prescale ratio and the largest legal BCD digit.
// Ports: none (package).
package countdown_pkg;

  // State encoding kept as plain constants so legacy code can compare
  // against raw values.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUN     = 2'd1;
  localparam state_t ST_PAUSE   = 2'd2;
  localparam state_t ST_EXPIRED = 2'd3;

  // CLK cycles per count tick (50 MHz clock -> one tick per second).
  localparam int unsigned PRESCALE_DEFAULT = 50000000;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Saturate a preset digit so the count never holds a non-BCD value.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// edge_detect
// Rising-edge detector: registers IN every cycle and flags the cycle in
// which IN is high while the previous sample was low. A held-high input
// therefore produces exactly one EDGE.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous, active-low reset (clears the stored sample)
//   IN   - synchronous level input
//   EDGE - high for the cycle in which IN first reads high
module edge_detect (
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  output logic EDGE
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = IN;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign EDGE = IN & ~prev_q;

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
// Two-digit BCD countdown timer. A preset is loaded with LOAD, a rising
// edge on START_STOP starts/pauses/resumes the countdown, and the count
// decrements once every PRESCALE clock cycles while running. Reaching 00
// enters EXPIRED, which pulses DONE once and holds BUZZ until acknowledged.
// Ports:
//   CLK, RST          - clock and asynchronous active-low reset
//   LOAD              - load preset digits (ignored while running)
//   LOAD_TENS/ONES    - BCD preset digits, values above 9 clamp to 9
//   START_STOP        - start/pause/resume/acknowledge on rising edge
//   TENS, ONES        - current count, BCD
//   RUNNING           - high while counting
//   DONE              - one-cycle pulse on expiry
//   BUZZ              - high while expired
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [3:0] LOAD_TENS,
  input  logic [3:0] LOAD_ONES,
  input  logic       START_STOP,
  output logic [3:0] TENS,
  output logic [3:0] ONES,
  output logic       RUNNING,
  output logic       DONE,
  output logic       BUZZ
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic ss_edge;
  logic tick;
  logic count_zero;
  logic count_last;

  edge_detect u_edge_detect (
    .CLK  (CLK),
    .RST  (RST),
    .IN   (START_STOP),
    .EDGE (ss_edge)
  );

  assign tick       = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
  assign count_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  // Treating 00 like 01 keeps the count from ever wrapping below zero.
  assign count_last = (tens_q == 4'd0) && (ones_q <= 4'd1);

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    if (state_q != ST_RUN && LOAD) begin
      // LOAD outranks any simultaneous START_STOP edge outside RUN.
      tens_d  = clamp_bcd(LOAD_TENS);
      ones_d  = clamp_bcd(LOAD_ONES);
      presc_d = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_edge && !count_zero) begin
            presc_d = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            presc_d = '0;
            if (count_last) begin
              // Expiry swallows any edge arriving in the same cycle.
              tens_d  = 4'd0;
              ones_d  = 4'd0;
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end else begin
              if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
              end else begin
                ones_d = BCD_MAX;
                tens_d = tens_q - 4'd1;
              end
              if (ss_edge) begin
                state_d = ST_PAUSE;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
            if (ss_edge) begin
              state_d = ST_PAUSE;
            end
          end
        end
        ST_PAUSE: begin
          // Prescaler is retained so the partial tick period resumes.
          if (ss_edge) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          if (ss_edge) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign TENS    = tens_q;
  assign ONES    = ones_q;
  assign RUNNING = (state_q == ST_RUN);
  assign DONE    = done_q;
  assign BUZZ    = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
// Self-checking bench for countdown_timer with PRESCALE=4. A behavioural
// model tracks the remaining count as an integer number of ticks and the
// elapsed cycles within the current tick; directed scenarios are followed
// by a randomized run, all compared against the model every cycle.
module tb_countdown_timer;

  localparam int PRESC = 4;

  logic       CLK;
  logic       RST;
  logic       LOAD;
  logic [3:0] LOAD_TENS;
  logic [3:0] LOAD_ONES;
  logic       START_STOP;
  logic [3:0] TENS;
  logic [3:0] ONES;
  logic       RUNNING;
  logic       DONE;
  logic       BUZZ;

  logic [10:0] dut_out;

  int pass_count;
  int check_count;

  typedef enum int {M_IDLE, M_RUN, M_HOLD, M_OVER} mode_t;

  mode_t m_mode;
  int    m_count;
  int    m_elapsed;
  bit    m_prev_ss;
  bit    m_done;

  countdown_timer #(.PRESCALE(PRESC)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD       (LOAD),
    .LOAD_TENS  (LOAD_TENS),
    .LOAD_ONES  (LOAD_ONES),
    .START_STOP (START_STOP),
    .TENS       (TENS),
    .ONES       (ONES),
    .RUNNING    (RUNNING),
    .DONE       (DONE),
    .BUZZ       (BUZZ)
  );

  assign dut_out = {TENS, ONES, RUNNING, DONE, BUZZ};

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Count one comparison and report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [10:0] modelOut();
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(m_count / 10);
    o = 4'(m_count % 10);
    return {t, o, (m_mode == M_RUN), m_done, (m_mode == M_OVER)};
  endfunction

  task automatic resetModel();
    m_mode    = M_IDLE;
    m_count   = 0;
    m_elapsed = 0;
    m_prev_ss = 1'b0;
    m_done    = 1'b0;
  endtask

  // One clock of the reference behaviour, given this cycle's inputs.
  task automatic stepModel(input bit ld, input int lt, input int lo, input bit ss);
    bit pressed;
    pressed   = ss && !m_prev_ss;
    m_prev_ss = ss;
    m_done    = 1'b0;
    if (m_mode != M_RUN && ld) begin
      m_count   = ((lt > 9) ? 9 : lt) * 10 + ((lo > 9) ? 9 : lo);
      m_elapsed = 0;
      m_mode    = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (pressed && m_count > 0) begin
          m_mode    = M_RUN;
          m_elapsed = 0;
        end
        M_HOLD: if (pressed) m_mode = M_RUN;
        M_OVER: if (pressed) m_mode = M_IDLE;
        M_RUN: begin
          m_elapsed++;
          if (m_elapsed == PRESC) begin
            m_elapsed = 0;
            m_count--;
            if (m_count == 0) begin
              m_mode = M_OVER;
              m_done = 1'b1;
            end else if (pressed) begin
              m_mode = M_HOLD;
            end
          end else if (pressed) begin
            m_mode = M_HOLD;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model, and compare after the edge.
  task automatic applyStimulus(input bit ld, input logic [3:0] lt,
                               input logic [3:0] lo, input bit ss);
    LOAD       = ld;
    LOAD_TENS  = lt;
    LOAD_ONES  = lo;
    START_STOP = ss;
    @(posedge CLK);
    stepModel(ld, int'(lt), int'(lo), ss);
    #1;
    checkOutput("model", 32'(dut_out), 32'(modelOut()));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulseReset();
    RST = 1'b0;
    #1;
    checkOutput("rst_async", 32'(dut_out), 32'd0);
    resetModel();
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    int done_seen;
    int rises;
    bit prev_run;
    bit ss;
    bit ld;
    logic [3:0] lt;
    logic [3:0] lo;

    pass_count  = 0;
    check_count = 0;
    resetModel();
    RST        = 1'b0;
    LOAD       = 1'b0;
    LOAD_TENS  = 4'd0;
    LOAD_ONES  = 4'd0;
    START_STOP = 1'b0;
    #12;
    checkOutput("reset_state", 32'(dut_out), 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Load 03 and run to expiry.
    applyStimulus(1, 4'd0, 4'd3, 0);
    applyStimulus(0, 4'd0, 4'd0, 1);
    checkOutput("run_after_edge", 32'(RUNNING), 32'd1);
    done_seen = 0;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(0, 4'd0, 4'd0, 0);
      if (DONE) done_seen++;
      if (i == 4)  checkOutput("cnt_02", 32'({TENS, ONES}), 32'h02);
      if (i == 8)  checkOutput("cnt_01", 32'({TENS, ONES}), 32'h01);
      if (i == 12) checkOutput("expire_done", 32'({TENS, ONES, DONE, BUZZ}), 32'h003);
    end
    checkOutput("done_once", 32'(done_seen), 32'd1);
    checkOutput("buzz_held", 32'(BUZZ), 32'd1);

    // Acknowledge expiry, then expire again and load with a coincident edge.
    applyStimulus(0, 4'd0, 4'd0, 1);
    checkOutput("ack_buzz_low", 32'({BUZZ, RUNNING}), 32'd0);
    applyStimulus(1, 4'd0, 4'd1, 0);
    applyStimulus(0, 4'd0, 4'd0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'd0, 4'd0, 0);
    checkOutput("expired_again", 32'(BUZZ), 32'd1);
    applyStimulus(1, 4'd1, 4'd2, 1);
    checkOutput("load_beats_edge", 32'({TENS, ONES, RUNNING, BUZZ}), 32'h048);

    // Borrow from tens, then clamp in IDLE.
    applyStimulus(0, 4'd0, 4'd0, 0);
    applyStimulus(1, 4'd1, 4'd0, 0);
    applyStimulus(0, 4'd0, 4'd0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'd0, 4'd0, 0);
    checkOutput("borrow_09", 32'({TENS, ONES}), 32'h09);
    applyStimulus(0, 4'd0, 4'd0, 1);
    applyStimulus(1, 4'd0, 4'd0, 0);
    applyStimulus(1, 4'd9, 4'd15, 0);
    checkOutput("clamp_99", 32'({TENS, ONES, RUNNING}), 32'h132);

    // Pause mid-tick and confirm the prescaler is retained on resume.
    applyStimulus(1, 4'd0, 4'd5, 0);
    applyStimulus(0, 4'd0, 4'd0, 1);
    applyStimulus(0, 4'd0, 4'd0, 0);
    applyStimulus(0, 4'd0, 4'd0, 1);
    checkOutput("paused", 32'(RUNNING), 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 4'd0, 4'd0, 0);
    checkOutput("pause_hold", 32'({TENS, ONES}), 32'h05);
    applyStimulus(0, 4'd0, 4'd0, 1);
    checkOutput("resumed", 32'(RUNNING), 32'd1);
    applyStimulus(0, 4'd0, 4'd0, 0);
    checkOutput("resume_pre_tick", 32'({TENS, ONES}), 32'h05);
    applyStimulus(0, 4'd0, 4'd0, 0);
    checkOutput("resume_tick", 32'({TENS, ONES}), 32'h04);

    // Held START_STOP yields one start; LOAD during RUN is ignored.
    applyStimulus(0, 4'd0, 4'd0, 1);
    applyStimulus(0, 4'd0, 4'd0, 0);
    applyStimulus(1, 4'd0, 4'd5, 0);
    rises    = 0;
    prev_run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 4'd0, 4'd0, 1);
      if (RUNNING && !prev_run) rises++;
      prev_run = RUNNING;
    end
    checkOutput("held_one_start", 32'({rises[3:0], RUNNING}), 32'h03);
    applyStimulus(1, 4'd9, 4'd9, 0);
    checkOutput("load_in_run", 32'({TENS, ONES, RUNNING}), 32'h007);

    // Reset in the middle of a countdown from 07.
    applyStimulus(0, 4'd0, 4'd0, 1);
    applyStimulus(0, 4'd0, 4'd0, 0);
    applyStimulus(1, 4'd0, 4'd7, 0);
    applyStimulus(0, 4'd0, 4'd0, 1);
    applyStimulus(0, 4'd0, 4'd0, 0);
    checkOutput("run_at_07", 32'({TENS, ONES, RUNNING}), 32'h00F);
    START_STOP = 1'b0;
    pulseReset();
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 4'd0, 4'd0, 0);
      if (DONE) done_seen++;
    end
    checkOutput("no_done_after_rst", 32'(done_seen), 32'd0);
    applyStimulus(0, 4'd0, 4'd0, 1);
    checkOutput("zero_stays_idle", 32'(RUNNING), 32'd0);

    // Randomized traffic against the model.
    ss = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      ld = ($urandom_range(0, 9) == 0);
      lt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      lo = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ss = ~ss;
      applyStimulus(ld, lt, lo, ss);
      if ($urandom_range(0, 299) == 0) begin
        ss = 1'b0;
        START_STOP = 1'b0;
        pulseReset();
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
